// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared mux constants, FSM state encoding and grant decode.
package rr_mux_arbiter_pkg;
  localparam int MUX_N = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;
  function automatic logic [MUX_N-1:0] sel2gnt(input logic [SEL_W-1:0] s);
    return {{(MUX_N-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: request/select bundle between requesters and arbiter; lock only with ARB_LOCK_EN.
interface rr_mux_arbiter_if;
  import rr_mux_arbiter_pkg::*;
  logic [MUX_N-1:0] req;
  logic             done;
`ifdef ARB_LOCK_EN
  logic             lock;
`endif
  logic [SEL_W-1:0] sel;
  logic [MUX_N-1:0] gnt;
  logic             valid;
`ifdef ARB_LOCK_EN
  modport master (output req, done, lock, input sel, gnt, valid);
  modport slave  (input req, done, lock, output sel, gnt, valid);
`else
  modport master (output req, done, input sel, gnt, valid);
  modport slave  (input req, done, output sel, gnt, valid);
`endif
endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// rr_pick4: combinational round-robin picker, scan starts after last and wraps.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [MUX_N-1:0] req_i,
  input  logic [MUX_N-1:0] mask_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [SEL_W-1:0] win_o,
  output logic             any_o
);
  logic [MUX_N-1:0] r;
  assign r = req_i & ~mask_i;
  // scanning farthest-first lets the nearest candidate overwrite
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    for (int i = MUX_N; i >= 1; i--)
      if (r[SEL_W'(last_i + SEL_W'(i))]) begin
        win_o = SEL_W'(last_i + SEL_W'(i));
        any_o = 1'b1;
      end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin arbiter driving registered mux select with bounded bursts.
// Define ARB_LOCK_EN to add a lock input that suppresses the burst timeout.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input logic            clk,
  input logic            rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
  state_e           state_q;
  logic [SEL_W-1:0] sel_q, last_q, win;
  logic [MUX_N-1:0] gnt_q, mask;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, any, lock, rel;
`ifdef ARB_LOCK_EN
  assign lock = bus.lock;
`else
  assign lock = 1'b0;
`endif
  assign mask = state_q == ST_GRANT ? sel2gnt(sel_q) : '0;
  assign rel  = bus.done || !bus.req[sel_q] || (cnt_q == CNT_MAX && !lock);
  rr_pick4 u_pick (
    .req_i  (bus.req),
    .mask_i (mask),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );
  // a timeout with no contender re-grants the owner; done or a dropped request idles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(MUX_N - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == ST_IDLE || rel) begin
      if (any) begin
        state_q <= ST_GRANT;
        sel_q   <= win;
        last_q  <= win;
        gnt_q   <= sel2gnt(win);
        valid_q <= 1'b1;
        cnt_q   <= '0;
      end else if (state_q == ST_GRANT && !bus.done && bus.req[sel_q]) begin
        cnt_q   <= '0;
      end else begin
        state_q <= ST_IDLE;
        gnt_q   <= '0;
        valid_q <= 1'b0;
        cnt_q   <= '0;
      end
    end else if (!lock && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench; inputs change and outputs are sampled on negedge.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  rr_mux_arbiter_if bus();
  rr_mux_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk_out(input string tag, input int s, input int v);
    check({tag, "_sel"}, 8'(bus.sel), 8'(s));
    check({tag, "_valid"}, 8'(bus.valid), 8'(v));
    check({tag, "_gnt"}, 8'(bus.gnt), v != 0 ? 8'(1 << s) : 8'h0);
  endtask
  initial begin
    bus.req  = 4'b1111;
    bus.done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    step();
    step();
    chk_out("reset", 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      check("full_sel", 8'(bus.sel), 8'((k / 4) % 4));
      check("full_valid", 8'(bus.valid), 8'h1);
    end
    step();
    chk_out("wrap_owner0", 0, 1);
    bus.req = 4'b0101;
    step();
    chk_out("done_second", 0, 1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_out("early_done", 2, 1);
    bus.req = 4'b1000;
    step();
    chk_out("drop_to3", 3, 1);
    bus.req = 4'b0001;
    step();
    chk_out("wrap_to0", 0, 1);
    bus.req = 4'b0000;
    step();
    chk_out("idle", 0, 0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_out("done_in_idle", 0, 0);
    bus.req = 4'b0010;
    step();
    chk_out("lone_first", 1, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk_out("lone_hold", 1, 1);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk_out("lone_done", 1, 0);
    step();
    chk_out("lone_regrant", 1, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 0, 0);
    step();
`ifdef ARB_LOCK_EN
    bus.req = 4'b0100;
    rst_n = 1'b1;
    step();
    chk_out("lock_owner2", 2, 1);
    bus.req  = 4'b1111;
    bus.lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("lock_hold", 8'(bus.sel), 8'd2);
    end
    bus.lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("unlock_count", 8'(bus.sel), 8'd2);
    end
    step();
    chk_out("unlock_release", 3, 1);
`else
    rst_n = 1'b1;
    step();
    chk_out("post_reset_first", 1, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
